// File: rtl/load_store_unit.sv
// Load/store unit between the execute/memory stage and a synchronous,
// byte-enabled data memory (18-bit byte address, 32-bit data).
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   req_valid/req_we   request present / 1 = store, 0 = load
//   req_size           00 byte, 01 half, 10/11 word
//   req_unsigned       zero-extend load result
//   req_addr/req_wdata byte address / right-justified store data
//   busy               stall; request accepted only when req_valid && !busy
//   rsp_valid/rsp_rdata load result valid / extended load result
//   mem_write, byte_en, write_addr, write_data   memory write port
//   read_addr, mem_rdata                         memory read port (1-cycle latency)
//
// Accesses crossing a word boundary are split into two consecutive memory
// accesses; busy is high during the second one.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [17:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        mem_write,
  output logic [3:0]  byte_en,
  output logic [17:0] write_addr,
  output logic [17:0] read_addr,
  output logic [31:0] write_data,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, LD_HI, ST_HI} state_t;

  state_t      state, state_nxt;

  logic [1:0]  req_off;
  logic [15:0] req_k;
  logic [3:0]  req_mask;
  logic        req_split;
  logic        accept;

  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_uns;
  logic        lat_split;
  logic [15:0] lat_k;
  logic [15:0] lat_k_inc;
  logic [3:0]  lat_mask;
  logic [31:0] lat_wdata;
  logic [31:0] lo_buf;
  logic        ld_pending;
  logic        ld_pending_nxt;

  logic [1:0]  sel_off;
  logic [3:0]  sel_mask;
  logic [31:0] sel_wdata;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;

  logic [63:0] rd_wide;
  logic [31:0] rd_src;
  logic [31:0] rd_ext;

  assign req_off   = req_addr[1:0];
  assign req_k     = req_addr[17:2];
  assign accept    = req_valid && (state == IDLE);
  assign lat_k_inc = lat_k + 16'd1;

  always_comb begin
    req_mask = 4'b1111;
    case (req_size)
      2'b00:   req_mask = 4'b0001;
      2'b01:   req_mask = 4'b0011;
      default: req_mask = 4'b1111;
    endcase
  end

  // Split when the access spills past byte lane 3.
  assign req_split = ((req_size == 2'b01) && (req_off == 2'd3)) ||
                     (req_size[1] && (req_off != 2'd0));

  // One shifter serves both halves of a store: the low half comes from the
  // live request in IDLE, the high half from the latched copy in ST_HI.
  assign sel_off   = (state == ST_HI) ? lat_off   : req_off;
  assign sel_mask  = (state == ST_HI) ? lat_mask  : req_mask;
  assign sel_wdata = (state == ST_HI) ? lat_wdata : req_wdata;
  assign be_wide   = {4'b0000, sel_mask} << sel_off;
  assign wd_wide   = {32'h0, sel_wdata} << {sel_off, 3'b000};

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    mem_write  = 1'b0;
    byte_en    = '0;
    write_data = '0;
    read_addr  = {req_k, 2'b00};
    write_addr = {req_k, 2'b00};
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_split) state_nxt = req_we ? ST_HI : LD_HI;
          if (req_we) begin
            mem_write  = 1'b1;
            byte_en    = be_wide[3:0];
            write_data = wd_wide[31:0];
          end
        end
      end
      LD_HI: begin
        busy       = 1'b1;
        read_addr  = {lat_k_inc, 2'b00};
        write_addr = {lat_k_inc, 2'b00};
        state_nxt  = IDLE;
      end
      ST_HI: begin
        busy       = 1'b1;
        read_addr  = {lat_k_inc, 2'b00};
        write_addr = {lat_k_inc, 2'b00};
        mem_write  = 1'b1;
        byte_en    = be_wide[7:4];
        write_data = wd_wide[63:32];
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Write strobes must stay quiet for the whole reset pulse, not just
    // after the state register has been cleared.
    if (rst) begin
      mem_write  = 1'b0;
      byte_en    = '0;
      write_data = '0;
    end
  end

  assign ld_pending_nxt = (accept && !req_we && !req_split) || (state == LD_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ld_pending <= 1'b0;
      lo_buf     <= '0;
      lat_off    <= '0;
      lat_size   <= '0;
      lat_uns    <= 1'b0;
      lat_split  <= 1'b0;
      lat_k      <= '0;
      lat_mask   <= '0;
      lat_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      ld_pending <= ld_pending_nxt;
      if (accept) begin
        lat_off   <= req_off;
        lat_size  <= req_size;
        lat_uns   <= req_unsigned;
        lat_split <= req_split;
        lat_k     <= req_k;
        lat_mask  <= req_mask;
        lat_wdata <= req_wdata;
      end
      if (state == LD_HI) lo_buf <= mem_rdata;
    end
  end

  assign rd_wide = lat_split ? {mem_rdata, lo_buf} : {32'h0, mem_rdata};
  assign rd_src  = 32'(rd_wide >> {lat_off, 3'b000});

  always_comb begin
    rd_ext = rd_src;
    case (lat_size)
      2'b00:   rd_ext = lat_uns ? {24'h0, rd_src[7:0]}  : {{24{rd_src[7]}},  rd_src[7:0]};
      2'b01:   rd_ext = lat_uns ? {16'h0, rd_src[15:0]} : {{16{rd_src[15]}}, rd_src[15:0]};
      default: rd_ext = rd_src;
    endcase
  end

  assign rsp_valid = ld_pending;
  assign rsp_rdata = ld_pending ? rd_ext : '0;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the core's execute/memory stage and the synchronous, byte-enabled data memory. It converts RISC-V byte/half/word load and store requests into word-addressed memory accesses with byte enables, and aligns and sign- or zero-extends read data. Misaligned accesses that cross a word boundary are split into two back-to-back memory accesses. The core is stalled with `busy` while the second access runs.

## Interface
Parameters:
- None. Address width 18 and data width 32 are fixed to match the data memory.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  core request present.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  funct3[1:0]: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned`  in  1  funct3[2]: zero-extend loads.
- `req_addr`  in  18  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `busy`  out  1  stall; a request is accepted only when `req_valid && !busy`.
- `rsp_valid`  out  1  load result valid this cycle.
- `rsp_rdata`  out  32  extended load result.
- `mem_write`  out  1  to data memory.
- `byte_en`  out  4  to data memory.
- `write_addr`  out  18  to data memory, word-aligned (bits [1:0] = 0).
- `read_addr`  out  18  to data memory, word-aligned.
- `write_data`  out  32  to data memory, lane-positioned.
- `mem_rdata`  in  32  data memory read data, valid one cycle after `read_addr`.

## Operation
Naming:
- o = `req_addr[1:0]`.
- k = `req_addr[17:2]`.
- mask = 0001, 0011, or 1111 for byte, half, or word.
- The access is split when o + size_bytes > 4: half at o=3, word at o=1..3.

States:
- IDLE: `busy`=0. `read_addr` = {k,00} combinationally from the request.
  - Aligned load: latch o/size/unsigned; set `ld_pending`.
  - Aligned store: `mem_write`=1 at {k,00}; `byte_en` = (mask<<o)[3:0]; `write_data` = (wdata<<8o)[31:0].
  - Split load: latch fields and k; go to LD_HI.
  - Split store: perform the first-word write as for an aligned store; latch k, mask, and wdata; go to ST_HI.
- LD_HI: `busy`=1. Capture `mem_rdata` (word k) into `lo_buf`. Drive `read_addr` = {k+1,00}. Set `ld_pending`; go to IDLE.
- ST_HI: `busy`=1. `mem_write`=1 at {k+1,00}; `byte_en` = (mask<<o)[7:4]; `write_data` = ({32'b0,wdata}<<8o)[63:32]. Go to IDLE.
- k+1 wraps modulo 2^16.

Response:
- `rsp_valid` = `ld_pending` (registered).
- Source = {`mem_rdata`, `lo_buf`} >> 8o for a split load, `mem_rdata` >> 8o otherwise.
- Extract [7:0], [15:0], or [31:0] by size. Sign-extend from bit 7/15 unless `req_unsigned`.

Outside accepted stores and ST_HI:
- `mem_write`=0, `byte_en`=0, `write_data`=0.
- `write_addr` = `read_addr`.

Stores never assert `rsp_valid`.

## Timing
- Aligned load accepted in cycle N: `rsp_valid`=1 and `rsp_rdata` valid in N+1. A new request may be accepted in N+1.
- Split load accepted in N: word k read in N, `busy`=1 in N+1 (word k+1 read), `rsp_valid`=1 in N+2. A new request may be accepted in N+2.
- Aligned store: memory is written at the end of cycle N.
- Split store: first part written at the end of N, second at the end of N+1. `busy`=1 in N+1.
- The core holds its next request stable while `busy`=1. Request inputs are ignored in LD_HI/ST_HI.
- Back-to-back: a load response in N+1 and the acceptance of a store in N+1 are independent.
- Reset (asynchronous, any state):
  - State = IDLE; `ld_pending`=0; `lo_buf`=0.
  - `busy`=0, `rsp_valid`=0, `rsp_rdata`=0.
  - `mem_write`=0, `byte_en`=0, `write_data`=0 while `rst`=1.
  - A first half already written by an interrupted split store is not undone. A pending split load produces no response.

## Test plan
- Memory word 1 (addr 0x004) = 0x8899AABB. LW at 0x004 -> next cycle `rsp_valid`=1, `rsp_rdata`=0x8899AABB, `busy` never asserted.
- Same memory. LB at 0x007 -> 0xFFFFFF88. LBU at 0x007 -> 0x00000088. LH at 0x006 -> 0xFFFF8899.
- Word 0 = 0x44332211, word 1 = 0x88776655. LW at 0x002 -> `read_addr` 0x000 then 0x004, `busy`=1 for one cycle, `rsp_rdata`=0x66554433 two cycles after accept.
- Memory zeroed. SH 0xBEEF at 0x003 -> first write `byte_en`=1000 at 0x000 with `write_data`=0xEF000000; second write `byte_en`=0001 at 0x004 with `write_data`=0x000000BE. Word 0 = 0xEF000000, word 1 = 0x000000BE.
- SW at 0x3FFFD (k = 0xFFFF) -> second write at `write_addr` 0x00000 (wrap), `byte_en`=0001.
- Assert `rst` during LD_HI of a split LW -> `busy`=0 and `rsp_valid`=0 immediately, no response after reset release. The next aligned LW completes normally.
